// File: rtl/smag_disp_pkg.sv
// Package: smag_disp_pkg
// Shared definitions for the sign-magnitude BCD display block:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - scan digit index constants (units, tens, hundreds, sign)
//   - 7-bit active-high glyph constants {g,f,e,d,c,b,a} and encoder codes
//   - result field widths and the double-dabble nibble adjust helper
package smag_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int RESULT_W = 9;
  localparam int SIGN_BIT = 8;
  localparam int MAG_W    = 8;
  localparam int BCD_W    = 12;

  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [1:0] DIG_SIGN     = 2'd3;

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/smag_bcd_display_seg7_encode.sv
// Module: seg7_encode
// Combinational glyph lookup for one display digit.
// Ports:
//   code  in   4  0-9 = decimal digit, 10 = minus, 15 (and others) = blank
//   seg   out  7  active-high segments {g,f,e,d,c,b,a}
// Polarity inversion for the board is handled by the parent.
module seg7_encode
  import smag_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    case (code)
      4'd0:       seg = GLYPH_0;
      4'd1:       seg = GLYPH_1;
      4'd2:       seg = GLYPH_2;
      4'd3:       seg = GLYPH_3;
      4'd4:       seg = GLYPH_4;
      4'd5:       seg = GLYPH_5;
      4'd6:       seg = GLYPH_6;
      4'd7:       seg = GLYPH_7;
      4'd8:       seg = GLYPH_8;
      4'd9:       seg = GLYPH_9;
      CODE_MINUS: seg = GLYPH_MINUS;
      default:    seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/smag_bcd_display.sv
// Module: smag_bcd_display
// Takes the 9-bit sign-magnitude ALU result, converts the magnitude to three
// BCD digits with a sequential double-dabble (one shift per clock) and drives
// a 4-digit multiplexed 7-segment display: sign, hundreds, tens, units.
// Parameters:
//   REFRESH_DIV     clocks each digit stays enabled before the scan advances (>=2)
//   SEG_ACTIVE_LOW  1: seg driven active-low, 0: active-high
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   in_valid    in_result holds a new value; in_ready: value can be taken
//   in_result   [8]=sign (1=negative), [7:0]=magnitude
//   conv_done   one-cycle pulse after the display registers update
//   an          one-hot digit enable, [0]=units [1]=tens [2]=hundreds [3]=sign
//   seg         segments {g,f,e,d,c,b,a}
// Configuration macro: LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens.
module smag_bcd_display
  import smag_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RESULT_W-1:0] in_result,
  output logic                conv_done,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  state_t             state, state_nxt;
  logic               accept;
  logic               sign_r;
  logic [MAG_W-1:0]   mag_sh;
  logic [BCD_W-1:0]   bcd;
  logic [2:0]         shift_cnt;
  logic [3:0]         disp_h, disp_t, disp_u;
  logic               disp_neg;
  logic [CNT_W-1:0]   refresh_cnt;
  logic [1:0]         scan_idx;
  logic [3:0]         code;
  logic [6:0]         seg_hi;

  assign in_ready = (state == IDLE) || (state == DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Eight SHIFT cycles (shift_cnt 0..7), then one DONE cycle that may accept
  // the next value directly, giving one accept per 9 cycles at best.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r    <= 1'b0;
      mag_sh    <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
    end else if (accept) begin
      sign_r    <= in_result[SIGN_BIT];
      mag_sh    <= in_result[MAG_W-1:0];
      bcd       <= '0;
      shift_cnt <= '0;
    end else if (state == SHIFT) begin
      {bcd, mag_sh} <= {dabble_adjust(bcd), mag_sh} << 1;
      shift_cnt     <= shift_cnt + 3'd1;
    end
  end

  // Commit happens on the DONE edge; a negative zero keeps the sign blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_h    <= '0;
      disp_t    <= '0;
      disp_u    <= '0;
      disp_neg  <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= (state == DONE);
      if (state == DONE) begin
        disp_h   <= bcd[11:8];
        disp_t   <= bcd[7:4];
        disp_u   <= bcd[3:0];
        disp_neg <= sign_r && (bcd != '0);
      end
    end
  end

  // Free-running scan, unaffected by conversions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= DIG_UNITS;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    code = disp_u;
    case (scan_idx)
      DIG_UNITS: code = disp_u;
      DIG_TENS: begin
        code = disp_t;
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_h == 4'd0 && disp_t == 4'd0) code = CODE_BLANK;
`endif
      end
      DIG_HUNDREDS: begin
        code = disp_h;
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_h == 4'd0) code = CODE_BLANK;
`endif
      end
      default: code = disp_neg ? CODE_MINUS : CODE_BLANK;
    endcase
  end

  assign an = 4'b0001 << scan_idx;

  seg7_encode u_seg7_encode (
    .code (code),
    .seg  (seg_hi)
  );

  assign seg = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule
